// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU (port 0) and loader/debug (port 1).
// Round-robin on ties, loader-only in boot mode, tagged one-cycle read return and CPU stall.
module dmem_arbiter #(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            boot_i,
  input  logic            req0_i,
  input  logic            req1_i,
  input  logic            we0_i,
  input  logic            we1_i,
  input  logic [AW-1:0]   addr0_i,
  input  logic [AW-1:0]   addr1_i,
  input  logic [DW-1:0]   wdata0_i,
  input  logic [DW-1:0]   wdata1_i,
  input  logic [DW/8-1:0] be0_i,
  input  logic [DW/8-1:0] be1_i,
  output logic            gnt0_o,
  output logic            gnt1_o,
  output logic            rvalid0_o,
  output logic            rvalid1_o,
  output logic [DW-1:0]   rdata_o,
  output logic            stall_o,
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_be_o,
  input  logic [DW-1:0]   mem_rdata_i
);

  localparam int BW = DW / 8;

  logic lg_reg;
  logic rtag_valid_reg;
  logic rtag_port_reg;
  logic gnt0;
  logic gnt1;
  logic any_gnt;

  // lg_reg holds the last granted port; on a tie the other port wins
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (boot_i) begin
      gnt1 = req1_i;
    end else if (req0_i && req1_i) begin
      gnt0 = lg_reg;
      gnt1 = ~lg_reg;
    end else begin
      gnt0 = req0_i;
      gnt1 = req1_i;
    end
  end

  assign any_gnt = gnt0 | gnt1;
  assign gnt0_o  = gnt0;
  assign gnt1_o  = gnt1;
  assign stall_o = req0_i & ~gnt0;

  always_comb begin
    mem_en_o    = any_gnt;
    mem_we_o    = 1'b0;
    mem_addr_o  = addr0_i;
    mem_wdata_o = wdata0_i;
    mem_be_o    = {BW{1'b0}};
    if (gnt1) begin
      mem_we_o    = we1_i;
      mem_addr_o  = addr1_i;
      mem_wdata_o = wdata1_i;
      mem_be_o    = be1_i;
    end else if (gnt0) begin
      mem_we_o    = we0_i;
      mem_be_o    = be0_i;
    end
  end

  // A read granted in a reset cycle still hits memory, but its tag is dropped
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lg_reg         <= 1'b1;
      rtag_valid_reg <= 1'b0;
      rtag_port_reg  <= 1'b0;
    end else begin
      if (any_gnt) begin
        lg_reg <= gnt1;
      end
      rtag_valid_reg <= any_gnt & ~mem_we_o;
      rtag_port_reg  <= gnt1;
    end
  end

  assign rvalid0_o = rtag_valid_reg & ~rtag_port_reg;
  assign rvalid1_o = rtag_valid_reg & rtag_port_reg;
  assign rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-enabled memory model behind it.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, boot;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [BW-1:0] be0, be1;
  logic          gnt0, gnt1, rvalid0, rvalid1, stall;
  logic [DW-1:0] rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [BW-1:0] mem_be;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst), .boot_i(boot),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .be0_i(be0), .be1_i(be1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .rvalid0_o(rvalid0), .rvalid1_o(rvalid1),
    .rdata_o(rdata), .stall_o(stall),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
  );

  // Memory model: word-indexed, registered read, preloaded on the first edge
  logic [DW-1:0] mem [0:255];
  logic          preload = 1'b1;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[4] <= 32'h1234_5678;
    end else if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < BW; b++)
          if (mem_be[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[9:2]];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
  endtask

  logic [3:0] exp_g0;
  logic [3:0] exp_g1;

  initial begin
    rst = 0; boot = 0; mem_rdata = '0;
    idle();
    cyc();
    preload = 0;
    rst = 1;
    @(negedge clk);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_rvalid1", rvalid1, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_stall", stall, 0);

    // Single CPU read of 0x10
    cyc();
    req0 = 1; we0 = 0; addr0 = 32'h10;
    @(negedge clk);
    $display("cpu read 0x10");
    check("rd_gnt0", gnt0, 1);
    check("rd_stall", stall, 0);
    check("rd_mem_en", mem_en, 1);
    check("rd_mem_we", mem_we, 0);
    check("rd_mem_addr", mem_addr, 32'h10);
    cyc();
    idle();
    @(negedge clk);
    check("rd_rvalid0", rvalid0, 1);
    check("rd_rvalid1", rvalid1, 0);
    check("rd_rdata", rdata, 32'h1234_5678);
    check("rd_stall2", stall, 0);

    // Both ports writing continuously from reset
    cyc();
    rst = 0;
    cyc();
    rst = 1;
    req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'h1111_1111; be0 = 4'hF;
    req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'h2222_2222; be1 = 4'hF;
    exp_g0 = 4'b0101;
    exp_g1 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      $display("contended write cycle %0d gnt0=%0b gnt1=%0b", i + 1, gnt0, gnt1);
      check("wr_gnt0", gnt0, exp_g0[i]);
      check("wr_gnt1", gnt1, exp_g1[i]);
      check("wr_stall", stall, exp_g1[i]);
      cyc();
    end
    idle();
    @(negedge clk);
    check("wr_no_rvalid0", rvalid0, 0);
    check("wr_no_rvalid1", rvalid1, 0);
    check("wr_mem_p0", mem[8], 32'h1111_1111);
    check("wr_mem_p1", mem[16], 32'h2222_2222);

    // Boot mode: loader only, then CPU wins once boot drops (lg=1)
    cyc();
    boot = 1;
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h40;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      $display("boot cycle %0d gnt0=%0b gnt1=%0b", j + 1, gnt0, gnt1);
      check("boot_gnt1", gnt1, 1);
      check("boot_gnt0", gnt0, 0);
      check("boot_stall", stall, 1);
      if (j > 0) begin
        check("boot_rvalid1", rvalid1, 1);
        check("boot_rdata", rdata, 32'h2222_2222);
      end
      cyc();
    end
    boot = 0;
    @(negedge clk);
    check("unboot_gnt0", gnt0, 1);
    check("unboot_gnt1", gnt1, 0);
    check("unboot_stall", stall, 0);
    check("unboot_rvalid1", rvalid1, 1);
    cyc();
    idle();
    @(negedge clk);
    check("unboot_rvalid0", rvalid0, 1);
    check("unboot_rvalid1b", rvalid1, 0);
    check("unboot_rdata", rdata, 32'h1234_5678);

    // Interleaved reads: CPU reads 0x40, then loader reads 0x10
    cyc();
    req0 = 1; we0 = 0; addr0 = 32'h40;
    @(negedge clk);
    check("il_gnt0", gnt0, 1);
    cyc();
    idle();
    req1 = 1; we1 = 0; addr1 = 32'h10;
    @(negedge clk);
    $display("interleaved reads: cpu return, loader issue");
    check("il_gnt1", gnt1, 1);
    check("il_rvalid0", rvalid0, 1);
    check("il_rvalid1", rvalid1, 0);
    check("il_rdata0", rdata, 32'h2222_2222);
    cyc();
    idle();
    @(negedge clk);
    check("il_rvalid1b", rvalid1, 1);
    check("il_rvalid0b", rvalid0, 0);
    check("il_rdata1", rdata, 32'h1234_5678);

    // Partial byte-enable write, then read it back
    cyc();
    req0 = 1; we0 = 1; addr0 = 32'h30; wdata0 = 32'hAABB_CCDD; be0 = 4'b0010;
    @(negedge clk);
    $display("cpu byte write 0x30 be=0010");
    check("be_gnt0", gnt0, 1);
    check("be_mem_we", mem_we, 1);
    check("be_mem_be", mem_be, 4'b0010);
    check("be_mem_wdata", mem_wdata, 32'hAABB_CCDD);
    cyc();
    idle();
    @(negedge clk);
    check("be_rvalid0", rvalid0, 0);
    check("be_rvalid1", rvalid1, 0);
    check("be_mem_word", mem[12], 32'h0000_CC00);
    cyc();
    req0 = 1; we0 = 0; addr0 = 32'h30;
    cyc();
    idle();
    @(negedge clk);
    check("be_rb_rvalid0", rvalid0, 1);
    check("be_rb_rdata", rdata, 32'h0000_CC00);

    // Read granted in a reset cycle: no rvalid, lg back to 1
    cyc();
    rst = 0;
    req0 = 1; we0 = 0; addr0 = 32'h10;
    @(negedge clk);
    $display("cpu read during reset");
    check("rr_gnt0", gnt0, 1);
    check("rr_mem_en", mem_en, 1);
    cyc();
    rst = 1;
    idle();
    @(negedge clk);
    check("rr_rvalid0", rvalid0, 0);
    check("rr_rvalid1", rvalid1, 0);
    cyc();
    req0 = 1; we0 = 0; addr0 = 32'h10;
    req1 = 1; we1 = 0; addr1 = 32'h40;
    @(negedge clk);
    check("rr_tie_gnt0", gnt0, 1);
    check("rr_tie_gnt1", gnt1, 0);
    cyc();
    idle();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter sharing the single-port data memory between the CPU load/store path (port 0) and the program loader/debug port (port 1). Grants at most one access per cycle, with round-robin fairness and a loader-priority boot mode. Returns read data to the requester that issued the read. Generates the CPU stall so the PC and register write-back freeze while a CPU access waits.

## Interface
Parameters:
- DW, 32, data width in bits
- AW, 32, address width in bits (byte address, passed through unchanged)

Ports:
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; synchronous, active-low (0 = reset, sampled on rising clk_i)
- boot_i  input  1  1 = loader strict priority; CPU requests never granted
- req0_i / req1_i  input  1 each  access request, ports 0 (CPU) / 1 (loader)
- we0_i / we1_i  input  1 each  1 = write, 0 = read
- addr0_i / addr1_i  input  AW each  byte address
- wdata0_i / wdata1_i  input  DW each  write data
- be0_i / be1_i  input  DW/8 each  byte enables for writes
- gnt0_o / gnt1_o  output  1 each  access accepted this cycle
- rvalid0_o / rvalid1_o  output  1 each  read data valid for that port
- rdata_o  output  DW  read data, shared by both ports; qualified by rvalid*
- stall_o  output  1  CPU stall = req0_i & ~gnt0_o
- mem_en_o  output  1  memory access strobe
- mem_we_o  output  1  memory write enable
- mem_addr_o  output  AW  memory address
- mem_wdata_o  output  DW  memory write data
- mem_be_o  output  DW/8  memory byte enables
- mem_rdata_i  input  DW  memory read data, valid the cycle after a read strobe

## Operation
- State: last-grant pointer lg (1 bit), read-tag register rtag (valid bit + port bit).
- Arbitration is combinational on the current cycle's inputs:
  - boot_i=1: gnt1 = req1; gnt0 = 0.
  - boot_i=0, only one request: that request is granted.
  - boot_i=0, both request: grant the port ≠ lg.
- At most one grant per cycle, so gnt0_o & gnt1_o is never 1.
- On a clock edge with any grant, lg ← the granted port. lg is unchanged when there is no grant, and it also updates during boot_i.
- Memory drive:
  - mem_en_o = gnt0|gnt1; mem_we_o, addr, wdata and be are muxed from the granted port.
  - With no grant, mem_en_o=0, mem_we_o=0 and mem_be_o=0. Address and data outputs are don't-care.
- Read return:
  - A granted read (we=0) sets rtag.valid=1 and rtag.port=granted port on the edge.
  - The next cycle, rvalid<port>_o = 1 and rdata_o = mem_rdata_i.
  - Writes never produce rvalid.
- Requesters hold req, we, addr, wdata and be stable until granted. Deasserting before grant cancels the request with no side effects.
- Back-to-back reads are pipelined: one read per cycle, and each rvalid is tagged independently.
- stall_o is combinational. It also asserts during a CPU write that has not yet been granted.

## Timing
- Reset (rst_i=0 at an edge): lg←1 (CPU wins the first tie), rtag.valid←0.
- Output values in the cycle after reset:
  - rvalid0_o=0, rvalid1_o=0, rdata_o=mem_rdata_i (unqualified).
  - gnt*, mem_* and stall_o follow the live inputs. Reset does not gate requests in that cycle.
- Latency:
  - grant is 0 cycles after request when uncontested;
  - read data is 1 cycle after grant;
  - a write is committed at the grant edge.
- Contention: with both ports requesting continuously, grants alternate every cycle. Maximum CPU wait is 1 cycle (boot_i=0).
- Reset mid-operation: a read granted in the reset cycle produces no rvalid, because rtag is cleared. The memory access itself still occurs.
- boot_i changes take effect in the same cycle. A read granted to the CPU before boot_i rose still returns its rvalid.

## Test plan
- Reset, then req0 read addr 0x10 alone, memory holding 0x1234_5678 → gnt0=1 same cycle; next cycle rvalid0=1, rdata=0x1234_5678; stall_o=0 throughout.
- Both ports request writes continuously for 4 cycles from reset → grant order 0,1,0,1; stall_o=1 on cycles 2 and 4; memory shows both ports' data at their addresses.
- boot_i=1, req0 and req1 asserted 3 cycles → gnt1 each cycle, gnt0=0, stall_o=1; drop boot_i → gnt0 the next cycle (lg=1).
- Interleaved reads: cycle n req0 read A, cycle n+1 req1 read B → rvalid0 at n+1 with mem[A], rvalid1 at n+2 with mem[B]; never both rvalid high.
- Write with be=4'b0010, wdata=0xAABBCCDD to a word holding 0 → word becomes 0x0000_CC00; no rvalid.
- Read granted in the same cycle rst_i=0 → no rvalid the next cycle; lg=1 afterwards.
